// File: rtl/sys_bus_axi4_master_if.sv
// AXI4 master-side channel bundle for the system-bus bridge.
// The master modport is the bridge's view, the slave modport the interconnect's.
interface sys_bus_axi4_master_if #(
    parameter int DW = 64,
    parameter int AW = 32,
    parameter int IW = 8
);
    // Write address channel
    logic [IW-1:0]   m_axi_awid;
    logic [AW-1:0]   m_axi_awaddr;
    logic [7:0]      m_axi_awlen;
    logic [2:0]      m_axi_awsize;
    logic [1:0]      m_axi_awburst;
    logic            m_axi_awvalid;
    logic            m_axi_awready;
    // Write data channel
    logic [DW-1:0]   m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic            m_axi_wlast;
    logic            m_axi_wvalid;
    logic            m_axi_wready;
    // Write response channel
    logic [IW-1:0]   m_axi_bid;
    logic [1:0]      m_axi_bresp;
    logic            m_axi_bvalid;
    logic            m_axi_bready;
    // Read address channel
    logic [IW-1:0]   m_axi_arid;
    logic [AW-1:0]   m_axi_araddr;
    logic [7:0]      m_axi_arlen;
    logic [2:0]      m_axi_arsize;
    logic [1:0]      m_axi_arburst;
    logic            m_axi_arvalid;
    logic            m_axi_arready;
    // Read data channel
    logic [IW-1:0]   m_axi_rid;
    logic [DW-1:0]   m_axi_rdata;
    logic [1:0]      m_axi_rresp;
    logic            m_axi_rlast;
    logic            m_axi_rvalid;
    logic            m_axi_rready;

    modport master (
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bid, m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/sys_bus_axi4_master.sv
// Simple system bus to AXI4 master bridge: each wen/ren strobe becomes one
// single-beat AXI4 write or read, answered by a one-cycle ack with error flag.
// A response timeout guarantees an ack within TO+1 cycles of the strobe.
module sys_bus_axi4_master #(
    parameter int DW = 64,
    parameter int AW = 32,
    parameter int IW = 8,
    parameter int TO = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          bus_wen_i,
    input  logic          bus_ren_i,
    input  logic [AW-1:0] bus_addr_i,
    input  logic [DW-1:0] bus_wdata_i,
    output logic [DW-1:0] bus_rdata_o,
    output logic          bus_ack_o,
    output logic          bus_err_o,
    sys_bus_axi4_master_if.master m_axi
);

    localparam int              SIZE      = $clog2(DW/8);
    localparam int              CW        = $clog2(TO + 2);
    localparam logic [AW-1:0]   ADDR_MASK = ~AW'(DW/8 - 1);
    localparam logic [CW-1:0]   CNT_TO    = CW'(TO);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_DRAIN
    } state_t;

    state_t        state_q;
    logic          is_wr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
    logic [AW-1:0] awaddr_q, araddr_q;
    logic [DW-1:0] wdata_q, rdata_q;
    logic          ack_q, err_q;

    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic aw_done, w_done, timeout;
    logic unused_sig;

    assign aw_hs   = awvalid_q & m_axi.m_axi_awready;
    assign w_hs    = wvalid_q  & m_axi.m_axi_wready;
    assign ar_hs   = arvalid_q & m_axi.m_axi_arready;
    assign b_hs    = bready_q  & m_axi.m_axi_bvalid;
    assign r_hs    = rready_q  & m_axi.m_axi_rvalid;
    // A channel is done once its valid is low or is being accepted this cycle.
    assign aw_done = ~awvalid_q | aw_hs;
    assign w_done  = ~wvalid_q  | w_hs;
    assign timeout = (cnt_q == CNT_TO);

    // IDs, last flags and the low response bit carry no meaning for single-beat OKAY/ERR decoding.
    assign unused_sig = ^{m_axi.m_axi_bid, m_axi.m_axi_rid, m_axi.m_axi_rlast,
                          m_axi.m_axi_bresp[0], m_axi.m_axi_rresp[0]};

    // Fixed single-beat, full-width, incrementing transfer attributes.
    assign m_axi.m_axi_awid    = IW'(0);
    assign m_axi.m_axi_arid    = IW'(0);
    assign m_axi.m_axi_awlen   = 8'd0;
    assign m_axi.m_axi_arlen   = 8'd0;
    assign m_axi.m_axi_awsize  = 3'(SIZE);
    assign m_axi.m_axi_arsize  = 3'(SIZE);
    assign m_axi.m_axi_awburst = 2'b01;
    assign m_axi.m_axi_arburst = 2'b01;
    assign m_axi.m_axi_wlast   = 1'b1;
    assign m_axi.m_axi_wstrb   = {(DW/8){1'b1}};

    assign m_axi.m_axi_awaddr  = awaddr_q;
    assign m_axi.m_axi_awvalid = awvalid_q;
    assign m_axi.m_axi_wdata   = wdata_q;
    assign m_axi.m_axi_wvalid  = wvalid_q;
    assign m_axi.m_axi_bready  = bready_q;
    assign m_axi.m_axi_araddr  = araddr_q;
    assign m_axi.m_axi_arvalid = arvalid_q;
    assign m_axi.m_axi_rready  = rready_q;

    assign bus_rdata_o = rdata_q;
    assign bus_ack_o   = ack_q;
    assign bus_err_o   = err_q;

    // Timeout counter: restarts at 1 on acceptance, counts busy cycles, saturates.
    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            if (bus_wen_i || bus_ren_i) cnt_d = CNT_ONE;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Transaction FSM with all bus and AXI outputs registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: asynchronous reset returns every output to idle at once, even mid-handshake.
        if (rst_i) begin
            state_q   <= S_IDLE;
            is_wr_q   <= 1'b0;
            cnt_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cnt_q <= cnt_d;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus_wen_i) begin
                        awaddr_q  <= bus_addr_i & ADDR_MASK;
                        wdata_q   <= bus_wdata_i;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        is_wr_q   <= 1'b1;
                        state_q   <= S_WR;
                    end else if (bus_ren_i) begin
                        araddr_q  <= bus_addr_i & ADDR_MASK;
                        arvalid_q <= 1'b1;
                        is_wr_q   <= 1'b0;
                        state_q   <= S_RD_ADDR;
                    end
                end
                S_WR: begin
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                    if (timeout) begin
                        ack_q    <= 1'b1;
                        err_q    <= 1'b1;
                        rdata_q  <= '0;
                        bready_q <= 1'b1;
                        state_q  <= S_DRAIN;
                    end else if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    // A response on the timeout cycle still wins.
                    if (b_hs) begin
                        bready_q <= 1'b0;
                        ack_q    <= 1'b1;
                        err_q    <= m_axi.m_axi_bresp[1];
                        state_q  <= S_IDLE;
                    end else if (timeout) begin
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state_q <= S_DRAIN;
                    end
                end
                S_RD_ADDR: begin
                    if (ar_hs) arvalid_q <= 1'b0;
                    if (timeout) begin
                        ack_q    <= 1'b1;
                        err_q    <= 1'b1;
                        rdata_q  <= '0;
                        rready_q <= 1'b1;
                        state_q  <= S_DRAIN;
                    end else if (ar_hs) begin
                        rready_q <= 1'b1;
                        state_q  <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (r_hs) begin
                        rready_q <= 1'b0;
                        ack_q    <= 1'b1;
                        err_q    <= m_axi.m_axi_rresp[1];
                        rdata_q  <= m_axi.m_axi_rdata;
                        state_q  <= S_IDLE;
                    end else if (timeout) begin
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Valids may not be withdrawn; wait out handshakes and the late response silently.
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                    if (ar_hs) arvalid_q <= 1'b0;
                    if (is_wr_q ? b_hs : r_hs) begin
                        bready_q <= 1'b0;
                        rready_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_bus_axi4_master.sv
// Self-checking bench for sys_bus_axi4_master: a delay-programmable AXI slave,
// directed and randomized transactions, and a transaction-level expectation model.
module tb_sys_bus_axi4_master;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int IW = 8;
    localparam int TO = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bus_wen = 1'b0;
    logic          bus_ren = 1'b0;
    logic [AW-1:0] bus_addr = '0;
    logic [DW-1:0] bus_wdata = '0;
    logic [DW-1:0] bus_rdata;
    logic          bus_ack;
    logic          bus_err;

    sys_bus_axi4_master_if #(.DW(DW), .AW(AW), .IW(IW)) axi ();

    sys_bus_axi4_master #(.DW(DW), .AW(AW), .IW(IW), .TO(TO)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus_wen_i   (bus_wen),
        .bus_ren_i   (bus_ren),
        .bus_addr_i  (bus_addr),
        .bus_wdata_i (bus_wdata),
        .bus_rdata_o (bus_rdata),
        .bus_ack_o   (bus_ack),
        .bus_err_o   (bus_err),
        .m_axi       (axi)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural AXI slave ----------------
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    logic [1:0]  resp_cfg = 2'b00;
    logic [63:0] rd_data_cfg = '0;

    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        aw_got, w_got, b_pend, r_pend;
    logic        s_bvalid, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [63:0] s_rdata, s_wdata;
    logic [31:0] s_awaddr, s_araddr;

    assign axi.m_axi_awready = axi.m_axi_awvalid && (aw_cnt >= aw_dly);
    assign axi.m_axi_wready  = axi.m_axi_wvalid  && (w_cnt  >= w_dly);
    assign axi.m_axi_arready = axi.m_axi_arvalid && (ar_cnt >= ar_dly);
    assign axi.m_axi_bvalid  = s_bvalid;
    assign axi.m_axi_bresp   = s_bresp;
    assign axi.m_axi_bid     = '0;
    assign axi.m_axi_rvalid  = s_rvalid;
    assign axi.m_axi_rresp   = s_rresp;
    assign axi.m_axi_rdata   = s_rdata;
    assign axi.m_axi_rid     = '0;
    assign axi.m_axi_rlast   = 1'b1;

    wire aw_hs = axi.m_axi_awvalid && axi.m_axi_awready;
    wire w_hs  = axi.m_axi_wvalid  && axi.m_axi_wready;
    wire ar_hs = axi.m_axi_arvalid && axi.m_axi_arready;
    wire b_hs  = axi.m_axi_bvalid  && axi.m_axi_bready;
    wire r_hs  = axi.m_axi_rvalid  && axi.m_axi_rready;

    // Slave: ready after a programmed wait, response after a programmed gap.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_bresp <= 2'b00; s_rresp <= 2'b00;
            s_rdata <= '0; s_wdata <= '0; s_awaddr <= '0; s_araddr <= '0;
        end else begin
            aw_cnt <= (axi.m_axi_awvalid && !axi.m_axi_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (axi.m_axi_wvalid  && !axi.m_axi_wready)  ? w_cnt + 1  : 0;
            ar_cnt <= (axi.m_axi_arvalid && !axi.m_axi_arready) ? ar_cnt + 1 : 0;
            if (aw_hs) begin aw_got <= 1'b1; s_awaddr <= axi.m_axi_awaddr; end
            if (w_hs)  begin w_got  <= 1'b1; s_wdata  <= axi.m_axi_wdata;  end
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                aw_got  <= 1'b0;
                w_got   <= 1'b0;
                s_bresp <= resp_cfg;
                if (b_dly == 0) s_bvalid <= 1'b1;
                else begin b_pend <= 1'b1; b_cnt <= b_dly; end
            end
            if (b_pend) begin
                if (b_cnt == 1) begin s_bvalid <= 1'b1; b_pend <= 1'b0; end
                b_cnt <= b_cnt - 1;
            end
            if (b_hs) s_bvalid <= 1'b0;
            if (ar_hs) begin
                s_araddr <= axi.m_axi_araddr;
                s_rdata  <= rd_data_cfg;
                s_rresp  <= resp_cfg;
                if (r_dly == 0) s_rvalid <= 1'b1;
                else begin r_pend <= 1'b1; r_cnt <= r_dly; end
            end
            if (r_pend) begin
                if (r_cnt == 1) begin s_rvalid <= 1'b1; r_pend <= 1'b0; end
                r_cnt <= r_cnt - 1;
            end
            if (r_hs) s_rvalid <= 1'b0;
        end
    end

    // Monitor: totals of acks and handshakes on every channel.
    int ack_n = 0, aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_n = 0;
    always @(posedge clk) begin
        if (bus_ack) ack_n <= ack_n + 1;
        if (aw_hs)   aw_n  <= aw_n + 1;
        if (w_hs)    w_n   <= w_n + 1;
        if (ar_hs)   ar_n  <= ar_n + 1;
        if (b_hs)    b_n   <= b_n + 1;
        if (r_hs)    r_n   <= r_n + 1;
    end

    // ---------------- reference model ----------------
    logic [63:0] model_mem [logic [31:0]];
    logic [63:0] last_rdata = '0;
    int exp_ack_n = 0, exp_wr_n = 0, exp_rd_n = 0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] default_data(input logic [31:0] a);
        return {~a, a};
    endfunction

    // One bus transaction with programmed slave behaviour; all expectations
    // come from the protocol rules: handshake cycle h, ack at h+1, or timeout at TO+1.
    task automatic run_txn(input bit is_wr, input bit both, input bit busy_ren,
                           input logic [31:0] addr, input logic [63:0] wdata,
                           input int awd, input int wd, input int ard, input int bd, input int rd,
                           input logic [1:0] resp);
        logic [31:0] aligned;
        logic [63:0] exp_rdata, got_rdata;
        logic        exp_err, got_err;
        int h, exp_ack, ack_c, aw_last, w_last, ar_last, n;
        bit timed_out;
        aligned = addr & ~32'h7;
        aw_dly = awd; w_dly = wd; ar_dly = ard; b_dly = bd; r_dly = rd;
        resp_cfg = resp;
        rd_data_cfg = model_mem.exists(aligned) ? model_mem[aligned] : default_data(aligned);
        h = is_wr ? ((awd > wd) ? awd : wd) + bd + 2 : ard + rd + 2;
        timed_out = (h > TO);
        if (timed_out) begin
            exp_ack = TO + 1; exp_err = 1'b1; exp_rdata = '0;
        end else begin
            exp_ack = h + 1; exp_err = resp[1];
            exp_rdata = is_wr ? last_rdata : rd_data_cfg;
        end
        ack_c = 0; aw_last = 0; w_last = 0; ar_last = 0;
        got_err = 1'b0; got_rdata = '0;

        @(posedge clk); #1;
        bus_addr = addr; bus_wdata = wdata;
        bus_wen = is_wr; bus_ren = !is_wr || both;
        @(posedge clk); #1;
        bus_wen = 1'b0; bus_ren = 1'b0;
        for (int c = 1; c <= TO + 10; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (busy_ren && c == 2) begin bus_ren = 1'b1; bus_addr = 32'h200; end
            if (busy_ren && c == 3) bus_ren = 1'b0;
            @(negedge clk);
            if (c == 1) begin
                if (is_wr) begin
                    check("c1_aw_w_valid", {62'd0, axi.m_axi_awvalid, axi.m_axi_wvalid}, 64'd3);
                    check("c1_awaddr", 64'(axi.m_axi_awaddr), 64'(aligned));
                    check("c1_wdata", axi.m_axi_wdata, wdata);
                    check("c1_wstrb", 64'(axi.m_axi_wstrb), 64'hFF);
                    check("c1_no_arvalid", 64'(axi.m_axi_arvalid), 64'd0);
                end else begin
                    check("c1_arvalid", 64'(axi.m_axi_arvalid), 64'd1);
                    check("c1_araddr", 64'(axi.m_axi_araddr), 64'(aligned));
                    check("c1_no_awvalid", 64'(axi.m_axi_awvalid | axi.m_axi_wvalid), 64'd0);
                end
            end
            if (axi.m_axi_awvalid) aw_last = c;
            if (axi.m_axi_wvalid)  w_last  = c;
            if (axi.m_axi_arvalid) ar_last = c;
            if (bus_ack) begin
                ack_c = c; got_err = bus_err; got_rdata = bus_rdata;
                break;
            end
        end
        check("ack_cycle", 64'(ack_c), 64'(exp_ack));
        check("ack_err", 64'(got_err), 64'(exp_err));
        check("ack_rdata", got_rdata, exp_rdata);
        @(posedge clk); @(negedge clk);
        check("ack_pulse", 64'(bus_ack), 64'd0);
        if (is_wr) begin
            check("aw_drop", 64'(aw_last), 64'(1 + awd));
            check("w_drop", 64'(w_last), 64'(1 + wd));
        end else begin
            check("ar_drop", 64'(ar_last), 64'(1 + ard));
        end
        n = timed_out ? h - (ack_c + 1) + 1 : 0;
        repeat (n) @(posedge clk);
        @(posedge clk); @(negedge clk);
        exp_ack_n++;
        if (is_wr) exp_wr_n++; else exp_rd_n++;
        check("ack_count", 64'(ack_n), 64'(exp_ack_n));
        check("aw_count", 64'(aw_n), 64'(exp_wr_n));
        check("w_count", 64'(w_n), 64'(exp_wr_n));
        check("b_count", 64'(b_n), 64'(exp_wr_n));
        check("ar_count", 64'(ar_n), 64'(exp_rd_n));
        check("r_count", 64'(r_n), 64'(exp_rd_n));
        if (is_wr) begin
            check("slave_awaddr", 64'(s_awaddr), 64'(aligned));
            check("slave_wdata", s_wdata, wdata);
            if (!resp[1]) model_mem[aligned] = wdata;
        end else begin
            check("slave_araddr", 64'(s_araddr), 64'(aligned));
        end
        last_rdata = exp_rdata;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        // Reset state and fixed transfer attributes
        check("rst_ctrl", {57'd0, axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_arvalid,
                           axi.m_axi_bready, axi.m_axi_rready, bus_ack, bus_err}, 64'd0);
        check("rst_rdata", bus_rdata, 64'd0);
        check("rst_addr", {axi.m_axi_awaddr, axi.m_axi_araddr}, 64'd0);
        check("rst_wdata", axi.m_axi_wdata, 64'd0);
        check("const_attr", 64'({axi.m_axi_awid, axi.m_axi_arid, axi.m_axi_awlen, axi.m_axi_arlen,
                                 axi.m_axi_awsize, axi.m_axi_arsize, axi.m_axi_awburst,
                                 axi.m_axi_arburst, axi.m_axi_wlast}),
              64'({8'h00, 8'h00, 8'h00, 8'h00, 3'd3, 3'd3, 2'b01, 2'b01, 1'b1}));

        // Zero-wait write, ack at c3
        run_txn(1, 0, 0, 32'h4000_0010, 64'h1122_3344_5566_7788, 0, 0, 0, 0, 0, 2'b00);
        // Read with ARREADY delayed 3 cycles
        model_mem[32'h4000_0008] = 64'hDEAD_BEEF_CAFE_F00D;
        run_txn(0, 0, 0, 32'h4000_0008, '0, 0, 0, 3, 0, 0, 2'b00);
        // WREADY at c1, AWREADY at c5, SLVERR
        run_txn(1, 0, 0, 32'h4000_0020, 64'hA5A5_5A5A_0F0F_F0F0, 4, 0, 0, 0, 0, 2'b10);
        // wen+ren together, then ren while busy: only the write is issued
        run_txn(1, 1, 1, 32'h0000_0100, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 1, 0, 2'b00);
        run_txn(0, 0, 0, 32'h0000_0100, '0, 0, 0, 0, 0, 2, 2'b00);
        // No B response for 40 cycles: timeout, drain, then a normal read
        run_txn(1, 0, 0, 32'h4000_0030, 64'h5555_6666_7777_8888, 0, 0, 0, 40, 0, 2'b00);
        run_txn(0, 0, 0, 32'h4000_0010, '0, 0, 0, 0, 0, 0, 2'b00);
        // Response on the exact timeout cycle wins; one cycle later loses
        run_txn(1, 0, 0, 32'h4000_0040, 64'h0000_1111_2222_3333, 0, 0, 0, 30, 0, 2'b00);
        run_txn(1, 0, 0, 32'h4000_0048, 64'h4444_5555_6666_7777, 0, 0, 0, 31, 0, 2'b00);
        run_txn(0, 0, 0, 32'h4000_0040, '0, 0, 0, 1, 29, 0, 2'b11);
        run_txn(0, 0, 0, 32'h4000_0048, '0, 0, 0, 0, 0, 31, 2'b00);
        // Unaligned addresses are forced to 8-byte alignment
        run_txn(1, 0, 0, 32'h4000_0057, 64'hFEDC_BA98_7654_3210, 1, 2, 0, 0, 0, 2'b01);
        run_txn(0, 0, 0, 32'h4000_0053, '0, 0, 0, 2, 0, 1, 2'b00);

        // Randomized traffic over a small address window
        for (int i = 0; i < 12; i++) begin
            bit          wr;
            logic [31:0] a;
            logic [63:0] d;
            int          bd;
            wr = 1'($urandom_range(0, 1));
            a  = 32'h1000 + 32'($urandom_range(0, 7) << 3) + 32'($urandom_range(0, 7));
            d  = {$urandom, $urandom};
            bd = ($urandom_range(0, 7) == 0) ? 35 : int'($urandom_range(0, 3));
            run_txn(wr, 0, 0, a, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), bd, int'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)));
        end

        // Asynchronous reset while arvalid is raised
        ar_dly = 10; r_dly = 0;
        @(posedge clk); #1;
        bus_addr = 32'h0000_0300; bus_ren = 1'b1;
        @(posedge clk); #1;
        bus_ren = 1'b0;
        @(negedge clk);
        check("pre_rst_arvalid", 64'(axi.m_axi_arvalid), 64'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_rst_ctrl", {59'd0, axi.m_axi_arvalid, axi.m_axi_rready, axi.m_axi_bready,
                                 bus_ack, bus_err}, 64'd0);
        check("async_rst_rdata", bus_rdata, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_rdata = '0;
        run_txn(0, 0, 0, 32'h4000_0008, '0, 0, 0, 1, 1, 0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_bus_axi4_master.md
# sys_bus_axi4_master

Bridge from the Red Pitaya simple system bus to an AXI4 master port. A bus-side initiator (the PS-independent control logic or a debug sequencer) issues single `wen`/`ren` strobes; the block converts each into one single-beat AXI4 write or read toward the interconnect and returns `ack` with read data and an error flag. It mirrors the existing AXI-slave-to-bus bridge from the opposite end, with the same 32-cycle timeout guarantee.

## Interface
- `DW`, default 64: data width, bus and AXI (32 or 64)
- `AW`, default 32: address width
- `IW`, default 8: AXI ID width
- `TO`, default 32: response timeout, cycles from request acceptance
- `clk_i`  in  1: clock, all logic on rising edge
- `rst_i`  in  1: reset, asynchronous, active-high
- `bus_wen_i` / `bus_ren_i`  in  1: single-cycle write/read request strobes
- `bus_addr_i`  in  AW: byte address, sampled with strobe
- `bus_wdata_i`  in  DW: write data, sampled with `bus_wen_i`
- `bus_rdata_o`  out  DW: read data, valid while `bus_ack_o`=1
- `bus_ack_o`  out  1: one-cycle completion pulse
- `bus_err_o`  out  1: qualifies `bus_ack_o`; 1 = SLVERR/DECERR or timeout
- `m_axi_awaddr` / `m_axi_araddr`  out  AW: transfer address, low log2(DW/8) bits forced 0
- `m_axi_awvalid`, `m_axi_wvalid`, `m_axi_arvalid`, `m_axi_bready`, `m_axi_rready`  out  1: handshakes
- `m_axi_awready`, `m_axi_wready`, `m_axi_arready`, `m_axi_bvalid`, `m_axi_rvalid`, `m_axi_rlast`  in  1: handshakes
- `m_axi_wdata`  out  DW; `m_axi_wstrb`  out  DW/8, all ones
- `m_axi_bresp`, `m_axi_rresp`  in  2; `m_axi_rdata`  in  DW; `m_axi_bid`, `m_axi_rid`  in  IW, ignored
- Constant outputs: `m_axi_awid`/`arid`=0 (IW), `awlen`/`arlen`=0 (8), `awsize`/`arsize`=log2(DW/8) (3), `awburst`/`arburst`=2'b01 (2), `wlast`=1

## Operation
- States: IDLE, WR (AW/W pending), WR_RESP, RD_ADDR, RD_DATA, DRAIN.
- IDLE: `bus_wen_i` → latch addr/wdata, go WR; else `bus_ren_i` → latch addr, go RD_ADDR. Both high same cycle: write accepted, read dropped.
- Strobes outside IDLE are ignored (no ack ever generated for them); initiator must wait for ack.
- WR: `awvalid` and `wvalid` raised together; each drops independently after its own handshake; both done → WR_RESP.
- WR_RESP: `bready`=1; on `bvalid` → ack, `err`=`bresp[1]`, IDLE.
- RD_ADDR: `arvalid`=1 until `arready` → RD_DATA. RD_DATA: `rready`=1; on `rvalid` → ack, rdata=`rdata`, `err`=`rresp[1]`, IDLE.
- Timeout counter: cleared to 1 at acceptance, increments each non-IDLE cycle; reaching `TO` before completion → ack with `err`=1, `rdata`=0, go DRAIN.
- DRAIN: any still-raised valid stays high until its handshake (AXI forbids withdrawal); `bready`/`rready`=1; after the outstanding response beat is consumed → IDLE, no second ack.
- Response that completes in the same cycle the counter hits `TO`: response wins, normal ack, no DRAIN.

## Timing
- All outputs registered. Reset values: all valids/readies 0, `bus_ack_o`=0, `bus_err_o`=0, `bus_rdata_o`=0, addr/wdata outputs 0, state IDLE, counter 0.
- Strobe at cycle 0 → `awvalid`/`wvalid` (or `arvalid`) high at cycle 1.
- `bready`/`rready` high from the cycle entering WR_RESP/RD_DATA.
- `bus_ack_o` high the cycle after the B/R handshake; minimum write latency, zero-wait slave: strobe c0, AW/W handshake c1, B handshake c2, ack c3. Read identical.
- `bus_rdata_o` holds last value except when updated at ack.
- Timeout ack at cycle `TO`+1 after strobe.
- `rst_i` mid-transaction: immediate return to reset values regardless of AXI state (system reset resets interconnect too).

## Test plan
- Write 0x1122334455667788 to 0x40000010, zero-wait slave, BRESP=00 → AW/W at c1 with wstrb=0xFF, awaddr=0x40000010, ack c3, err=0.
- Read 0x40000008, ARREADY delayed 3 cycles, RDATA=0xDEADBEEF_CAFEF00D, RRESP=00 → arvalid held c1–c4, ack with rdata matching, err=0.
- Write with WREADY at c1, AWREADY at c5, BRESP=10 → wvalid drops c2, awvalid drops c6, ack with err=1.
- wen and ren same cycle, addresses 0x100/0x200 → only write at 0x100 issued, exactly one ack; ren during busy ignored.
- No B response for 40 cycles → ack err=1 at c33, then late BVALID consumed in DRAIN, no extra ack, next request works.
- `rst_i` asserted while `arvalid`=1 → arvalid, ack, err 0 asynchronously, state IDLE; post-reset read completes normally.
